ftm_tile_scheduler: RTL

Sequences one convolution layer through the double-buffered feature-map buffers, tile by tile along x. It accepts a layer descriptor, then alternates between two banks. It commands the DDR loader to fill one bank while the buffer reader drains the other, so loading and reading overlap. It sits between the layer sequencer (descriptor source) and the loader and buffer-reader datapath blocks.

---
 rtl/ftm_tile_scheduler.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ftm_tile_scheduler.sv
// Ping-pong tile scheduler: overlaps DDR loads into one feature-map bank with
// reads from the other, stepping through the x-tiles of one convolution layer.
module ftm_tile_scheduler #(
  parameter int B_SHAPE = 32,
  parameter int B_TILE  = 8,
  parameter int N_BANK  = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [B_SHAPE-1:0] cfg_wei_shape,
  input  logic [B_SHAPE-1:0] cfg_ftm_shape,
  input  logic [B_TILE-1:0]  cfg_n_tiles,
  output logic [B_SHAPE-1:0] wei_shape,
  output logic [B_SHAPE-1:0] ftm_shape,
  output logic               ld_start,
  output logic               ld_bank,
  output logic [B_TILE-1:0]  ld_tile,
  input  logic               ld_done,
  output logic               rd_start,
  output logic               rd_bank,
  output logic [B_TILE-1:0]  rd_tile,
  input  logic               rd_done,
  output logic               busy,
  output logic               layer_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [B_TILE-1:0] TILE_ONE = {{(B_TILE-1){1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [B_TILE-1:0] n_tiles;
  logic [B_TILE-1:0] ld_cnt;
  logic [B_TILE-1:0] rd_cnt;
  logic [B_TILE-1:0] ld_tile_q;
  logic [B_TILE-1:0] rd_tile_q;
  logic [N_BANK-1:0] bank_full;
  logic              ld_ptr;
  logic              rd_ptr;
  logic              ld_pend;
  logic              rd_pend;
  logic              ld_bank_q;
  logic              rd_bank_q;

  logic accept;
  logic ld_fin;
  logic rd_fin;
  logic rd_last;

  assign cfg_ready  = (state == S_IDLE);
  assign accept     = cfg_valid & cfg_ready;
  assign layer_done = (state == S_DONE);

  // Issue decisions look only at registered flags, so a bank filled or freed
  // this cycle becomes eligible on the next one.
  assign ld_start = (state == S_RUN) && !ld_pend && (ld_cnt < n_tiles) &&
                    !bank_full[ld_ptr] && !(rd_pend && (rd_bank_q == ld_ptr));
  assign rd_start = (state == S_RUN) && !rd_pend && bank_full[rd_ptr];

  // During the start pulse the target comes straight from the pointers; the
  // registered copy then holds it until the next start.
  assign ld_bank = ld_start ? ld_ptr : ld_bank_q;
  assign ld_tile = ld_start ? ld_cnt : ld_tile_q;
  assign rd_bank = rd_start ? rd_ptr : rd_bank_q;
  assign rd_tile = rd_start ? rd_cnt : rd_tile_q;

  assign ld_fin  = ld_pend & ld_done;
  assign rd_fin  = rd_pend & rd_done;
  assign rd_last = rd_fin && (rd_cnt == (n_tiles - TILE_ONE));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      n_tiles   <= '0;
      ld_cnt    <= '0;
      rd_cnt    <= '0;
      ld_tile_q <= '0;
      rd_tile_q <= '0;
      bank_full <= '0;
      ld_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      ld_pend   <= 1'b0;
      rd_pend   <= 1'b0;
      ld_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      busy      <= 1'b0;
      wei_shape <= '0;
      ftm_shape <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            wei_shape <= cfg_wei_shape;
            ftm_shape <= cfg_ftm_shape;
            n_tiles   <= cfg_n_tiles;
            ld_cnt    <= '0;
            rd_cnt    <= '0;
            bank_full <= '0;
            ld_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            ld_pend   <= 1'b0;
            rd_pend   <= 1'b0;
            busy      <= 1'b1;
            state     <= (cfg_n_tiles != '0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          if (ld_start) begin
            ld_pend   <= 1'b1;
            ld_bank_q <= ld_ptr;
            ld_tile_q <= ld_cnt;
          end
          if (rd_start) begin
            rd_pend   <= 1'b1;
            rd_bank_q <= rd_ptr;
            rd_tile_q <= rd_cnt;
          end
          // A start and a finish of the same kind never coincide, and the
          // two finishes always touch different banks.
          if (ld_fin) begin
            bank_full[ld_bank_q] <= 1'b1;
            ld_ptr               <= ~ld_ptr;
            ld_cnt               <= ld_cnt + TILE_ONE;
            ld_pend              <= 1'b0;
          end
          if (rd_fin) begin
            bank_full[rd_bank_q] <= 1'b0;
            rd_ptr               <= ~rd_ptr;
            rd_cnt               <= rd_cnt + TILE_ONE;
            rd_pend              <= 1'b0;
          end
          if (rd_last) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
